rca_nbit: RTL and testbench

- N-bit ripple-carry adder built from a chain of N one-bit full-adder cells.
- Produces a purely combinational sum and carry-out.
- Also provides a registered copy of the result, captured on the clock, for downstream synchronous logic.
- Used as the basic arithmetic primitive in datapaths where carry-chain delay is acceptable.

---
 rtl/rca_nbit.sv | 83 ++++++++
 tb/tb_rca_nbit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder with a registered copy of the result.
// Optional signed-overflow outputs (ovf, ovf_q) when RCA_NBIT_OVF_EN is defined.
module rca_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module rca_nbit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out,
`ifdef RCA_NBIT_OVF_EN
    output logic         ovf,
    output logic         ovf_q,
`endif
    output logic [N-1:0] s_q,
    output logic         c_out_q
);
    logic [N:0]   w_c;
    logic [N-1:0] w_s;
    logic [N-1:0] r_s;
    logic         r_c;

    assign w_c[0] = c_in;

    // Each cell consumes the carry produced by the cell below it.
    for (genvar i = 0; i < N; i++) begin : g_fa
        rca_fa u_fa (
            .i_a (a[i]),
            .i_b (b[i]),
            .i_c (w_c[i]),
            .o_s (w_s[i]),
            .o_c (w_c[i+1])
        );
    end

    assign s     = w_s;
    assign c_out = w_c[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= '0;
            r_c <= 1'b0;
        end else begin
            r_s <= w_s;
            r_c <= w_c[N];
        end
    end

    assign s_q     = r_s;
    assign c_out_q = r_c;

`ifdef RCA_NBIT_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // For N = 1, w_c[N-1] is c_in, which is the required degenerate case.
    assign w_ovf = w_c[N] ^ w_c[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf   = w_ovf;
    assign ovf_q = r_ovf;
`endif
endmodule

// File: tb/tb_rca_nbit.sv
// Self-checking bench for rca_nbit against an arithmetic reference model.
// Define RCA_NBIT_OVF_EN to also check the overflow outputs.
module tb_rca_nbit;
    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic [N-1:0] s;
    logic         c_out;
    logic [N-1:0] s_q;
    logic         c_out_q;
`ifdef RCA_NBIT_OVF_EN
    logic         ovf;
    logic         ovf_q;
`endif

    int checks = 0;
    int errors = 0;

    // Expected registered values (what the model says was captured last edge).
    logic [N:0] exp_q;
    logic       exp_ovf_q;

    rca_nbit #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .s       (s),
        .c_out   (c_out),
`ifdef RCA_NBIT_OVF_EN
        .ovf     (ovf),
        .ovf_q   (ovf_q),
`endif
        .s_q     (s_q),
        .c_out_q (c_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N:0] ref_sum(input logic [N-1:0] x,
                                           input logic [N-1:0] y,
                                           input logic ci);
        int t;
        t = int'(x) + int'(y) + int'(ci);
        return t[N:0];
    endfunction

    // Signed overflow: the exact signed sum leaves the N-bit signed range.
    function automatic logic ref_ovf(input logic [N-1:0] x,
                                     input logic [N-1:0] y,
                                     input logic ci);
        int sx, sy, t;
        sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
        sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
        t  = sx + sy + int'(ci);
        return (t > (1 << (N-1)) - 1) || (t < -(1 << (N-1)));
    endfunction

    task automatic check_comb(input string name);
        logic [N:0] e;
        e = ref_sum(a, b, c_in);
        checks++;
        if ({c_out, s} !== e) begin
            errors++;
            $display("FAIL %s comb: got %0h expected %0h", name, {c_out, s}, e);
        end
`ifdef RCA_NBIT_OVF_EN
        checks++;
        if (ovf !== ref_ovf(a, b, c_in)) begin
            errors++;
            $display("FAIL %s ovf: got %b expected %b", name, ovf,
                     ref_ovf(a, b, c_in));
        end
`endif
    endtask

    task automatic check_reg(input string name);
        checks++;
        if ({c_out_q, s_q} !== exp_q) begin
            errors++;
            $display("FAIL %s reg: got %0h expected %0h", name,
                     {c_out_q, s_q}, exp_q);
        end
`ifdef RCA_NBIT_OVF_EN
        checks++;
        if (ovf_q !== exp_ovf_q) begin
            errors++;
            $display("FAIL %s ovf_q: got %b expected %b", name, ovf_q,
                     exp_ovf_q);
        end
`endif
    endtask

    // Drive at negedge, check comb, clock, check the captured value.
    task automatic apply(input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic ci, input string name);
        @(negedge clk);
        a = x; b = y; c_in = ci;
        #1 check_comb(name);
        @(posedge clk);
        exp_q     = ref_sum(x, y, ci);
        exp_ovf_q = ref_ovf(x, y, ci);
        #1 check_reg(name);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        exp_q = '0; exp_ovf_q = 1'b0;
        #1 check_reg("reset_init");
        check_comb("reset_comb");
        @(posedge clk);
        #1 check_reg("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        apply('0, '0, 1'b0, "zero");
    endtask

    task automatic test_directed;
        apply(4'd15, 4'd1, 1'b0, "ripple");
        apply(4'd15, 4'd15, 1'b1, "all_ones");
        apply(4'd7, 4'd1, 1'b0, "pos_ovf");
        apply(4'd8, 4'd8, 1'b0, "neg_ovf");
    endtask

    // Inputs change every 2 time units; only the value at the edge is captured.
    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a = N'($urandom); b = N'($urandom); c_in = 1'($urandom);
            #2 check_comb("rand_a");
            check_reg("rand_hold_a");
            a = N'($urandom); b = N'($urandom); c_in = 1'($urandom);
            #2 check_comb("rand_b");
            check_reg("rand_hold_b");
            @(posedge clk);
            exp_q     = ref_sum(a, b, c_in);
            exp_ovf_q = ref_ovf(a, b, c_in);
            #1 check_reg("rand_cap");
        end
    endtask

    task automatic test_midcycle_reset;
        apply(4'd9, 4'd5, 1'b0, "load_14");
        @(negedge clk);
        rst_n = 1'b0;
        exp_q = '0; exp_ovf_q = 1'b0;
        #1 check_reg("async_clear");
        check_comb("comb_in_reset");
        @(posedge clk);
        #1 check_reg("reset_blocks");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_reg("release_wait");
        @(posedge clk);
        exp_q     = ref_sum(a, b, c_in);
        exp_ovf_q = ref_ovf(a, b, c_in);
        #1 check_reg("restore_14");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_midcycle_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
